// File: rtl/reset_sequencer_if.sv
// Reset sequencer control/status bundle.
//   master : drives clk_enable, locked, soft_reset_req; observes the reset tree.
//   slave  : the sequencer; consumes controls, drives domain_reset, ready, state.
// Ports carried:
//   clk_enable      1            advance state and counters when high
//   locked          1            clock-lock indication, asynchronous to clk
//   soft_reset_req  1            level-sensitive software/debug reset request
//   domain_reset    NUM_DOMAINS  per-domain active-high reset
//   ready           1            all domains released
//   state           2            0=HOLD, 1=RELEASE, 2=RUN
interface reset_sequencer_if #(
  parameter int unsigned NUM_DOMAINS = 3
) ();

  logic                   clk_enable;
  logic                   locked;
  logic                   soft_reset_req;
  logic [NUM_DOMAINS-1:0] domain_reset;
  logic                   ready;
  logic [1:0]             state;

  modport master (
    output clk_enable,
    output locked,
    output soft_reset_req,
    input  domain_reset,
    input  ready,
    input  state
  );

  modport slave (
    input  clk_enable,
    input  locked,
    input  soft_reset_req,
    output domain_reset,
    output ready,
    output state
  );

endinterface

// File: rtl/reset_sequencer.sv
// Reset tree sequencer for the 6502 core and its peripherals.
// Holds all reset domains asserted until the clock has been locked for
// MIN_HOLD enabled cycles, then releases domains 0..NUM_DOMAINS-1 one at a
// time, STAGE_DELAY enabled cycles apart. Loss of lock or a soft reset
// request re-asserts every domain at once and restarts from HOLD.
// Ports:
//   clk          system clock
//   async_reset  asynchronous active-high reset (forces HOLD, all domains asserted)
//   bus          reset_sequencer_if.slave (clk_enable, locked, soft_reset_req in;
//                domain_reset, ready, state out; all outputs registered)
module reset_sequencer #(
  parameter int unsigned NUM_DOMAINS = 3,
  parameter int unsigned MIN_HOLD    = 8,
  parameter int unsigned STAGE_DELAY = 16
) (
  input  logic              clk,
  input  logic              async_reset,
  reset_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(MIN_HOLD);
  localparam logic [CNT_W-1:0] STAGE_TC = CNT_W'(STAGE_DELAY);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] ONE_HOT0 = NUM_DOMAINS'(1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  state_e                 state_q;
  logic [NUM_DOMAINS-1:0] domain_reset_q;
  logic                   ready_q;
  logic [CNT_W-1:0]       hold_cnt;
  logic [CNT_W-1:0]       stage_cnt;
  logic [IDX_W-1:0]       stage_idx;

  logic lock_meta;
  logic locked_s;

  // Two-flop lock synchronizer; runs every cycle independent of clk_enable.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= bus.locked;
      locked_s  <= lock_meta;
    end
  end

  // Abort request seen by RELEASE and RUN.
  logic abort_c;
  assign abort_c = !locked_s || bus.soft_reset_req;

  // Sequencer FSM with registered outputs; frozen while clk_enable is low.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q        <= ST_HOLD;
      domain_reset_q <= '1;
      ready_q        <= 1'b0;
      hold_cnt       <= '0;
      stage_cnt      <= '0;
      stage_idx      <= '0;
    end else if (bus.clk_enable) begin
      unique case (state_q)
        ST_HOLD: begin
          domain_reset_q <= '1;
          ready_q        <= 1'b0;
          if (abort_c) begin
            hold_cnt <= '0;
          end else if (hold_cnt + CNT_W'(1) == HOLD_TC) begin
            // Lock has been stable long enough; start releasing.
            state_q   <= ST_RELEASE;
            hold_cnt  <= '0;
            stage_cnt <= '0;
            stage_idx <= '0;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (abort_c) begin
            // Abort beats any release scheduled on this edge.
            state_q        <= ST_HOLD;
            domain_reset_q <= '1;
            ready_q        <= 1'b0;
            hold_cnt       <= '0;
            stage_cnt      <= '0;
            stage_idx      <= '0;
          end else if (stage_cnt + CNT_W'(1) == STAGE_TC) begin
            stage_cnt <= '0;
            stage_idx <= stage_idx + IDX_W'(1);
            if (stage_idx == LAST_IDX) begin
              state_q        <= ST_RUN;
              domain_reset_q <= '0;
              ready_q        <= 1'b1;
            end else begin
              domain_reset_q <= domain_reset_q & ~(ONE_HOT0 << stage_idx);
            end
          end else begin
            stage_cnt <= stage_cnt + CNT_W'(1);
          end
        end

        ST_RUN: begin
          if (abort_c) begin
            state_q        <= ST_HOLD;
            domain_reset_q <= '1;
            ready_q        <= 1'b0;
            hold_cnt       <= '0;
            stage_cnt      <= '0;
            stage_idx      <= '0;
          end else begin
            domain_reset_q <= '0;
            ready_q        <= 1'b1;
          end
        end

        default: begin
          state_q        <= ST_HOLD;
          domain_reset_q <= '1;
          ready_q        <= 1'b0;
          hold_cnt       <= '0;
          stage_cnt      <= '0;
          stage_idx      <= '0;
        end
      endcase
    end
  end

  assign bus.domain_reset = domain_reset_q;
  assign bus.ready        = ready_q;
  assign bus.state        = 2'(state_q);

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters.
module tb_reset_sequencer;

  localparam int unsigned ND = 3;

  logic clk = 1'b0;
  logic async_reset;

  reset_sequencer_if #(.NUM_DOMAINS(ND)) bus ();

  reset_sequencer #(
    .NUM_DOMAINS (ND),
    .MIN_HOLD    (8),
    .STAGE_DELAY (16)
  ) dut (
    .clk         (clk),
    .async_reset (async_reset),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [ND-1:0] dr;
    logic          rdy;
    logic [1:0]    st;
  } exp_t;

  exp_t exp_q[$];
  int   n_asserts = 0;
  int   n_fails   = 0;
  int   ec        = 0;
  bit   gate_mode = 1'b0;

  // One clock edge; sampling point is the following falling edge.
  task automatic tick();
    if (gate_mode) bus.clk_enable = (((ec + 1) % 2) == 1);
    @(negedge clk);
    ec++;
  endtask

  task automatic push_exp(input string tag, input logic [ND-1:0] dr,
                          input logic rdy, input logic [1:0] st);
    exp_t e;
    e.tag = tag; e.dr = dr; e.rdy = rdy; e.st = st;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    e = exp_q.pop_front();
    n_asserts++;
    assert ({bus.domain_reset, bus.ready, bus.state} === {e.dr, e.rdy, e.st})
    else begin
      n_fails++;
      $error("FAIL %s @edge %0d: observed dr=%b ready=%b state=%0d, expected dr=%b ready=%b state=%0d",
             e.tag, ec, bus.domain_reset, bus.ready, bus.state, e.dr, e.rdy, e.st);
    end
  endtask

  task automatic at_edge(input int n, input string tag, input logic [ND-1:0] dr,
                         input logic rdy, input logic [1:0] st);
    push_exp(tag, dr, rdy, st);
    while (ec < n) tick();
    check_out();
  endtask

  task automatic window(input int from, input int to, input string tag,
                        input logic [ND-1:0] dr, input logic rdy, input logic [1:0] st);
    for (int e = from; e <= to; e++) at_edge(e, tag, dr, rdy, st);
  endtask

  // Assert reset at a falling edge, check immediate effect, release at next falling edge.
  task automatic do_reset();
    async_reset = 1'b1;
    #1;
    push_exp("reset_values", 3'b111, 1'b0, 2'd0);
    check_out();
    @(negedge clk);
    async_reset = 1'b0;
    ec = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    async_reset        = 1'b1;
    bus.clk_enable     = 1'b1;
    bus.locked         = 1'b1;
    bus.soft_reset_req = 1'b0;
    @(negedge clk);

    // Nominal release
    do_reset();
    window(1, 9, "nom_hold", 3'b111, 1'b0, 2'd0);
    at_edge(10, "nom_rel_entry", 3'b111, 1'b0, 2'd1);
    at_edge(25, "nom_pre_d0", 3'b111, 1'b0, 2'd1);
    at_edge(26, "nom_d0", 3'b110, 1'b0, 2'd1);
    at_edge(41, "nom_pre_d1", 3'b110, 1'b0, 2'd1);
    at_edge(42, "nom_d1", 3'b100, 1'b0, 2'd1);
    at_edge(57, "nom_pre_d2", 3'b100, 1'b0, 2'd1);
    at_edge(58, "nom_run", 3'b000, 1'b1, 2'd2);
    at_edge(62, "nom_run_stay", 3'b000, 1'b1, 2'd2);

    // Lock glitch in HOLD: locked low for the cycle of edge 6
    do_reset();
    window(1, 5, "gl_hold_a", 3'b111, 1'b0, 2'd0);
    bus.locked = 1'b0;
    at_edge(6, "gl_hold_b", 3'b111, 1'b0, 2'd0);
    bus.locked = 1'b1;
    window(7, 15, "gl_hold_c", 3'b111, 1'b0, 2'd0);
    at_edge(16, "gl_rel_entry", 3'b111, 1'b0, 2'd1);
    at_edge(31, "gl_pre_d0", 3'b111, 1'b0, 2'd1);
    at_edge(32, "gl_d0", 3'b110, 1'b0, 2'd1);
    at_edge(48, "gl_d1", 3'b100, 1'b0, 2'd1);
    at_edge(63, "gl_pre_d2", 3'b100, 1'b0, 2'd1);
    at_edge(64, "gl_run", 3'b000, 1'b1, 2'd2);

    // Lock loss in RUN, then recovery
    at_edge(66, "ll_run", 3'b000, 1'b1, 2'd2);
    bus.locked = 1'b0;
    at_edge(68, "ll_sync_delay", 3'b000, 1'b1, 2'd2);
    at_edge(69, "ll_abort", 3'b111, 1'b0, 2'd0);
    at_edge(70, "ll_hold", 3'b111, 1'b0, 2'd0);
    bus.locked = 1'b1;
    window(71, 79, "ll_rehold", 3'b111, 1'b0, 2'd0);
    at_edge(80, "ll_rel_entry", 3'b111, 1'b0, 2'd1);
    at_edge(95, "ll_pre_d0", 3'b111, 1'b0, 2'd1);
    at_edge(96, "ll_d0", 3'b110, 1'b0, 2'd1);
    at_edge(112, "ll_d1", 3'b100, 1'b0, 2'd1);
    at_edge(127, "ll_pre_d2", 3'b100, 1'b0, 2'd1);
    at_edge(128, "ll_run", 3'b000, 1'b1, 2'd2);

    // Soft reset on the edge domain 1 would release
    do_reset();
    at_edge(41, "sr_pre", 3'b110, 1'b0, 2'd1);
    bus.soft_reset_req = 1'b1;
    at_edge(42, "sr_abort_wins", 3'b111, 1'b0, 2'd0);
    bus.soft_reset_req = 1'b0;
    window(43, 49, "sr_hold", 3'b111, 1'b0, 2'd0);
    at_edge(50, "sr_rel_entry", 3'b111, 1'b0, 2'd1);
    at_edge(65, "sr_pre_d0", 3'b111, 1'b0, 2'd1);
    at_edge(66, "sr_d0", 3'b110, 1'b0, 2'd1);

    // clk_enable alternating during RELEASE (odd edges enabled)
    do_reset();
    at_edge(10, "ce_rel_entry", 3'b111, 1'b0, 2'd1);
    gate_mode = 1'b1;
    at_edge(40, "ce_pre_d0", 3'b111, 1'b0, 2'd1);
    at_edge(41, "ce_d0", 3'b110, 1'b0, 2'd1);
    at_edge(42, "ce_off_hold", 3'b110, 1'b0, 2'd1);
    at_edge(72, "ce_pre_d1", 3'b110, 1'b0, 2'd1);
    at_edge(73, "ce_d1", 3'b100, 1'b0, 2'd1);
    at_edge(74, "ce_off_hold2", 3'b100, 1'b0, 2'd1);
    at_edge(104, "ce_pre_d2", 3'b100, 1'b0, 2'd1);
    at_edge(105, "ce_run", 3'b000, 1'b1, 2'd2);
    at_edge(106, "ce_run_off", 3'b000, 1'b1, 2'd2);
    gate_mode = 1'b0;
    bus.clk_enable = 1'b1;

    // Async reset pulse between edges during RELEASE
    do_reset();
    at_edge(30, "ar_mid_rel", 3'b110, 1'b0, 2'd1);
    #1;
    async_reset = 1'b1;
    #1;
    push_exp("ar_immediate", 3'b111, 1'b0, 2'd0);
    check_out();
    #1;
    async_reset = 1'b0;
    ec = 0;
    window(1, 9, "ar_hold", 3'b111, 1'b0, 2'd0);
    at_edge(10, "ar_rel_entry", 3'b111, 1'b0, 2'd1);
    at_edge(26, "ar_d0", 3'b110, 1'b0, 2'd1);
    at_edge(42, "ar_d1", 3'b100, 1'b0, 2'd1);
    at_edge(58, "ar_run", 3'b000, 1'b1, 2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sequences the system reset tree for the 6502 core and its peripherals.
- Takes the synchronized power-on reset as `async_reset`, a clock-lock indication and a software/debug reset request.
- Holds every reset domain asserted until the clock is stable, then releases the domains one at a time, in index order, with a fixed spacing between releases.
- Re-asserts all domains immediately on loss of lock or on a reset request.

Parameters:
- NUM_DOMAINS, 3, number of reset domains; domain 0 is released first; range 1..8.
- MIN_HOLD, 8, number of consecutive enabled cycles with lock high required before release sequencing begins; range 1..255.
- STAGE_DELAY, 16, number of enabled cycles between entering RELEASE or a prior release and the next domain release; range 1..255.

Ports:
- clk  input  1  system clock.
- async_reset  input  1  asynchronous, active-high reset.
- clk_enable  input  1  advances the state machine and counters only when 1.
- locked  input  1  clock-lock indication; asynchronous to clk.
- soft_reset_req  input  1  synchronous reset request; level-sensitive.
- domain_reset  output  NUM_DOMAINS  per-domain reset; active-high.
- ready  output  1  high when all domains are released.
- state  output  2  current state: 0=HOLD, 1=RELEASE, 2=RUN.

Behaviour:
- One clock `clk`. Reset `async_reset` is asynchronous and active-high.
- While `async_reset` is high, all flops are cleared/preset immediately:
  - domain_reset = all ones.
  - ready = 0, state = HOLD.
  - Both lock-synchronizer flops = 0.
  - hold_cnt = 0, stage_cnt = 0, stage_idx = 0.
- Lock synchronizer:
  - Two flops; locked_s is the second flop.
  - Both flops shift on every edge, regardless of clk_enable.
- Edge numbering: edge 1 is the first rising edge after `async_reset` falls.
- All transitions below occur only on edges where clk_enable = 1, except the lock synchronizer.

State HOLD:
- domain_reset = all ones, ready = 0.
- If locked_s = 0, hold_cnt <= 0.
- Otherwise hold_cnt increments.
- On the edge where hold_cnt reaches MIN_HOLD: go to RELEASE, stage_cnt <= 0, stage_idx <= 0.
- soft_reset_req in HOLD clears hold_cnt to 0.

State RELEASE:
- stage_cnt increments each enabled edge.
- On the edge where stage_cnt reaches STAGE_DELAY:
  - domain_reset[stage_idx] <= 0.
  - stage_cnt <= 0.
  - stage_idx increments.
- On the edge that releases domain NUM_DOMAINS-1: go to RUN, and ready <= 1 on the same edge.

State RUN:
- domain_reset = all zeros, ready = 1.
- Remain here until an abort condition occurs.

Abort rules:
- If locked_s = 0 or soft_reset_req = 1 in RELEASE or RUN, on that enabled edge:
  - domain_reset <= all ones, ready <= 0.
  - state <= HOLD, hold_cnt <= 0.
- Abort has priority over a release scheduled on the same edge.
- Abort does not assert any domain on an edge where clk_enable = 0.

Domain ordering and combinations:
- Released domains never re-assert individually; re-assertion is always all domains together.
- `async_reset` during any state forces the reset values immediately.
- Sequencing restarts from HOLD after reset.
- clk_enable low: all state and counters freeze, outputs hold their values.

Counters and outputs:
- Counters are 8 bits and never wrap: HOLD and RELEASE both exit or clear at their terminal count.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
- Nominal release. Defaults, clk_enable = 1, locked = 1 from reset, soft_reset_req = 0 → locked_s high at edge 2, RELEASE entered at edge 10, domain_reset = 110 after edge 26, 100 after edge 42, 000 and ready = 1 after edge 58, state = 2.
- Lock glitch in HOLD. locked drops for 1 cycle around edge 6 → hold_cnt clears; all release times shift later by the glitch offset; domain_reset stays 111 throughout HOLD.
- Lock loss in RUN. From RUN, drop locked → 2 edges later domain_reset = 111, ready = 0, state = 0. Restore locked → full sequence repeats with identical spacing.
- Soft reset vs. release. Assert soft_reset_req on the edge domain 1 would release → domain_reset = 111 (abort wins), state = HOLD. With locked still high, domain 0 releases MIN_HOLD + STAGE_DELAY = 24 edges after that edge.
- clk_enable gating. Toggle clk_enable 1-0-1-0 during RELEASE → each release occurs after exactly STAGE_DELAY enabled edges, i.e. 32 clk edges apart; outputs constant on disabled edges.
- Async reset mid-sequence. Pulse async_reset between clock edges in RELEASE → domain_reset = 111, ready = 0, state = 0 before the next edge; nominal timing repeats from the new edge 1.
